sram_ctrl: RTL

Memory-side responder for the data cache. It accepts the cache's miss-fill reads and write-through writes and performs them as fixed-wait-state accesses on the 16-bit external SRAM bus. It holds `ready` low for the duration, which freezes the pipeline. It sits between the cache/memory stage of `dataPath` and the SRAM pins, and runs on the `clk_SRAM` domain.

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the cache-side SRAM responder.
// Holds the FSM state encoding and the external bus geometry.
package sram_pkg;

    localparam int          SRAM_AW           = 18;
    localparam int          SRAM_DW           = 16;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } sram_state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Fixed-wait-state responder for the data cache: 64-bit block reads and 32-bit writes
// carried out as 16-bit accesses on the external SRAM bus, stalling via ready.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [31:0]          address,
    input  logic [31:0]          write_data,
    output logic [63:0]          read_data,
    output logic                 ready,
    inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
    output logic [SRAM_AW-1:0]   SRAM_ADDR,
    output logic                 SRAM_WE_N
);

    localparam int CNT_W = $clog2(4 * WAIT_CYCLES) + 1;
    localparam int WIN_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(4 * WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(2 * WAIT_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WAIT_CYCLES - 1);

    sram_state_t      state_reg, state_next;
    logic             is_write_reg;
    logic [16:0]      word_idx_reg;
    logic [31:0]      wdata_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIN_W-1:0] win_reg;
    logic [1:0]       k_reg;
    logic [63:0]      read_data_reg;

    logic             request;
    logic             in_access;
    logic             access_write;
    logic             win_last;
    logic             term_count;
    logic [16:0]      req_word;

    assign request      = wr_en | rd_en;
    assign in_access    = (state_reg == ACCESS);
    assign access_write = in_access & is_write_reg;
    assign win_last     = (win_reg == WIN_LAST);
    assign term_count   = (cnt_reg == (is_write_reg ? WR_LAST : RD_LAST));
    // Offset wraps modulo 2^32; only the word-index bits survive the truncation.
    assign req_word     = 17'((address - BASE_ADDR) >> 2);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (request) state_next = ACCESS;
            ACCESS:  if (term_count) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            is_write_reg <= 1'b0;
            word_idx_reg <= '0;
            wdata_reg    <= '0;
            cnt_reg      <= '0;
            win_reg      <= '0;
            k_reg        <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE) begin
                if (request) begin
                    // Write wins when both requests arrive together.
                    is_write_reg <= wr_en;
                    word_idx_reg <= req_word;
                    wdata_reg    <= write_data;
                end
                cnt_reg <= '0;
                win_reg <= '0;
                k_reg   <= '0;
            end else if (in_access) begin
                cnt_reg <= cnt_reg + 1'b1;
                if (win_last) begin
                    win_reg <= '0;
                    k_reg   <= k_reg + 1'b1;
                end else begin
                    win_reg <= win_reg + 1'b1;
                end
            end
        end
    end

    // One capture lane per halfword of the returned block.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    read_data_reg[16*gi +: 16] <= '0;
                end else if (in_access && !is_write_reg && win_last && (k_reg == 2'(gi))) begin
                    read_data_reg[16*gi +: 16] <= SRAM_DQ;
                end
            end
        end
    endgenerate

    always_comb begin
        SRAM_ADDR = '0;
        if (in_access) begin
            SRAM_ADDR = is_write_reg ? {word_idx_reg, k_reg[0]}
                                     : {word_idx_reg[16:1], k_reg};
        end
    end

    assign SRAM_WE_N = ~access_write;
    assign SRAM_DQ   = access_write ? (k_reg[0] ? wdata_reg[31:16] : wdata_reg[15:0])
                                    : {SRAM_DW{1'bz}};
    assign read_data = read_data_reg;
    assign ready     = (state_reg == DONE) | ((state_reg == IDLE) & ~request);

endmodule
